dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port data memory. Port 0 is the pipeline MEM stage; port 1 is the debug/DMA loader.
//  Arbitrates round-robin, latches the winning request and drives the memory Memwrite/Memread/addr/data_in strobes for one cycle.
//  Returns read data, a done pulse and an error flag to the owning port.
//  Memory reads are synchronous: data_out is valid the cycle after Memread.
// PARAMETERS
//  ADDR_W     32  request/memory address width
//  DATA_W     32  data width
//  MEM_DEPTH  64  number of valid word locations; addr >= MEM_DEPTH is out of range
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  rN_req     in   1       (N=0,1) request; hold it and its fields stable until rN_gnt
//  rN_we      in   1       1 = write, 0 = read
//  rN_addr    in   ADDR_W  word address
//  rN_wdata   in   DATA_W  write data
//  rN_gnt     out  1       request accepted; 1-cycle pulse
//  rN_done    out  1       access complete; 1-cycle pulse
//  rN_err     out  1       with done: address out of range, no memory access made
//  rN_rdata   out  DATA_W  read data; valid when rN_done & ~err & read
//  mem_write  out  1       to memory Memwrite
//  mem_read   out  1       to memory Memread
//  mem_addr   out  ADDR_W  to memory addr
//  mem_wdata  out  DATA_W  to memory data_in
//  mem_rdata  in   DATA_W  from memory data_out
// BEHAVIOUR
//  Reset (asynchronous):
//  - FSM=IDLE, last_owner=1 so port 0 wins the first tie.
//  - All gnt/done/err/mem_write/mem_read go 0 immediately; mem_addr/mem_wdata/latches go 0.
//  - Any in-flight access is dropped with no done pulse.
//  FSM:
//  - IDLE: arbitrate; if any req -> ACCESS.
//  - ACCESS (1 cycle): gnt to owner. Drive mem_* from latched owner/we/addr/wdata. If addr >= MEM_DEPTH, mem_write=mem_read=0. -> RESP.
//  - RESP (1 cycle): done to owner; err if out of range. Read rdata = mem_rdata, else 0; non-owner rdata=0.
//    Arbitrate again: any req -> ACCESS, else -> IDLE.
//  - Strobes are decoded from state and registered latches only; no combinational path from rN_* to mem_*.
//  Arbitration (IDLE and RESP only):
//  - One requester wins. Both requesting: the port != last_owner wins.
//  - last_owner updates on entry to ACCESS.
//  Handshake:
//  - req is ignored during ACCESS (the gnt cycle). A req seen in RESP/IDLE is a new request.
//  - Requester drops req or presents its next request the cycle after gnt.
//  Latency and throughput:
//  - req sampled at edge E -> gnt in cycle after E, done one cycle later.
//  - Minimum 2 cycles per access; back-to-back accesses every 2 cycles.
//  Data: addresses compared unsigned against MEM_DEPTH. Write data and address pass unmodified. The latch captures at the edge entering ACCESS.
// TESTING
//  1. Assert rst mid-run -> all outputs 0 within the cycle. After release, FSM IDLE, no gnt without req.
//  2. Port0 write addr 5 data 32'hDEADBEEF, then read addr 5 -> each gets gnt then done 1 cycle later; read returns 32'hDEADBEEF with err=0.
//  3. Both ports request reads every cycle -> gnt order 0,1,0,1. Each port is granted every 4 cycles.
//  4. Port1 write to addr 64 (MEM_DEPTH) -> gnt, then done+err. mem_write stays 0; read of addr 0 is unaffected.
//  5. rst pulsed during ACCESS of a port0 write of 32'h1234 to addr 7 -> mem_write deasserts before the edge and no done. Later read of addr 7 returns the prior value.
//  6. Port1 alone holds req continuously with port0 idle -> gnt every 2 cycles. mem_read pulses once per grant and never two cycles in a row.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer for the single-port data memory: req -> gnt next cycle -> done one cycle later.
// A losing or blocked requester simply holds req; one access every 2 cycles at best.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic any_req;
    logic win;
    logic in_range;
    logic in_access;
    logic in_resp;
    logic rd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // On a tie the port that did not own the previous access wins.
    assign any_req = r0_req | r1_req;
    assign win     = (r0_req & r1_req) ? ~last_q : r1_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    state_d = ACCESS;
                    owner_d = win;
                    last_d  = win;
                    we_d    = win ? r1_we    : r0_we;
                    addr_d  = win ? r1_addr  : r0_addr;
                    wdata_d = win ? r1_wdata : r0_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state so memory strobes never see a req glitch.
    assign in_range  = (addr_q < DEPTH_L);
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign rd_ok     = in_resp & ~we_q & in_range;

    assign mem_write = in_access & we_q & in_range;
    assign mem_read  = in_access & ~we_q & in_range;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign r0_gnt   = in_access & ~owner_q;
    assign r1_gnt   = in_access & owner_q;
    assign r0_done  = in_resp & ~owner_q;
    assign r1_done  = in_resp & owner_q;
    assign r0_err   = r0_done & ~in_range;
    assign r1_err   = r1_done & ~in_range;
    assign r0_rdata = (rd_ok & ~owner_q) ? mem_rdata : '0;
    assign r1_rdata = (rd_ok & owner_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random and directed traffic from two ports against a word-array memory model and scoreboard.
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        gnt_s   [2];
    logic        done_s  [2];
    logic        err_s   [2];
    logic [31:0] rdata_s [2];
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    op_t         pend    [2][$];
    rsp_t        exp_q   [2][$];
    int          gcyc    [2][$];
    int          gseq    [$];
    logic        await_q [2];
    logic        prev_req[2];
    logic        prev_mr;
    logic        tb_last;
    logic [31:0] last_rd [2];
    int          mw_cnt;
    int          cyc;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (req_s[0]),
        .r0_we     (we_s[0]),
        .r0_addr   (addr_s[0]),
        .r0_wdata  (wdata_s[0]),
        .r0_gnt    (gnt_s[0]),
        .r0_done   (done_s[0]),
        .r0_err    (err_s[0]),
        .r0_rdata  (rdata_s[0]),
        .r1_req    (req_s[1]),
        .r1_we     (we_s[1]),
        .r1_addr   (addr_s[1]),
        .r1_wdata  (wdata_s[1]),
        .r1_gnt    (gnt_s[1]),
        .r1_done   (done_s[1]),
        .r1_err    (err_s[1]),
        .r1_rdata  (rdata_s[1]),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read single-port memory.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end else begin
            if (mem_write) mem_arr[mem_addr[5:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem_arr[mem_addr[5:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    endtask

    // Scoreboard/monitor: requests are resolved against the reference array in grant order.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                exp_q[p].delete();
                await_q[p] = 1'b0;
                prev_req[p] = 1'b0;
            end
            prev_mr = 1'b0;
            tb_last = 1'b1;
        end else begin
            logic nxt_await [2];
            if (gnt_s[0] && gnt_s[1]) chk(0, "gnt_exclusive", 32'd3, 32'd1);
            for (int p = 0; p < 2; p++) begin
                nxt_await[p] = 1'b0;
                if (gnt_s[p]) begin
                    op_t  o;
                    rsp_t r;
                    chk(prev_req[p] && pend[p].size() > 0, "gnt_has_req", 32'(p), 32'(p));
                    if (prev_req[0] && prev_req[1])
                        chk(32'(p) != 32'(tb_last), "arb_rr", 32'(p), 32'(!tb_last));
                    tb_last = 1'(p);
                    gcyc[p].push_back(cyc);
                    gseq.push_back(p);
                    nxt_await[p] = 1'b1;
                    if (pend[p].size() > 0) begin
                        o = pend[p].pop_front();
                        r.we  = o.we;
                        r.err = (o.addr >= 32'd64);
                        if (r.err) begin
                            chk(!mem_write && !mem_read, "oor_no_strobe", {30'd0, mem_write, mem_read}, 32'd0);
                        end else begin
                            chk(mem_addr == o.addr, "mem_addr", mem_addr, o.addr);
                            chk(mem_write == o.we && mem_read == !o.we, "mem_strobe",
                                {30'd0, mem_write, mem_read}, {30'd0, o.we, !o.we});
                            if (o.we) begin
                                chk(mem_wdata == o.wdata, "mem_wdata", mem_wdata, o.wdata);
                                ref_mem[o.addr[5:0]] = o.wdata;
                            end
                        end
                        r.rdata = (!o.we && !r.err) ? ref_mem[o.addr[5:0]] : 32'd0;
                        exp_q[p].push_back(r);
                    end
                end
                if (await_q[p]) chk(done_s[p], "done_latency", {31'd0, done_s[p]}, 32'd1);
                else if (done_s[p]) chk(0, "done_unexpected", 32'(p), 32'd0);
                if (done_s[p]) begin
                    chk(rdata_s[1-p] == 32'd0, "nonowner_rdata", rdata_s[1-p], 32'd0);
                    if (exp_q[p].size() > 0) begin
                        rsp_t r;
                        r = exp_q[p].pop_front();
                        chk(err_s[p] == r.err, "err", {31'd0, err_s[p]}, {31'd0, r.err});
                        chk(rdata_s[p] == r.rdata, "rdata", rdata_s[p], r.rdata);
                        if (!r.we && !r.err) last_rd[p] = rdata_s[p];
                    end
                end
            end
            if (mem_write || mem_read) chk(mem_addr < 32'd64, "strobe_range", mem_addr, 32'd63);
            if (mem_read) chk(!prev_mr, "mem_read_b2b", {31'd0, prev_mr}, 32'd0);
            if (mem_write) mw_cnt++;
            prev_mr = mem_read;
            for (int p = 0; p < 2; p++) begin
                await_q[p]  = nxt_await[p];
                prev_req[p] = req_s[p];
            end
        end
    end

    // Present one request (after 'gap' idle cycles); returns just after the edge entering RESP.
    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d, input int gap);
        op_t o;
        int  n;
        if (gap > 0) begin
            req_s[p] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        req_s[p] = 1'b1;
        we_s[p] = w;
        addr_s[p] = a;
        wdata_s[p] = d;
        o.we = w;
        o.addr = a;
        o.wdata = d;
        pend[p].push_back(o);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_s[p] && n < 50);
        if (!gnt_s[p]) chk(0, "gnt_timeout", 32'(p), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_s[0] = 1'b0;
        req_s[1] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk(!gnt_s[0] && !gnt_s[1] && !done_s[0] && !done_s[1] && !err_s[0] && !err_s[1]
            && !mem_write && !mem_read && rdata_s[0] == 0 && rdata_s[1] == 0,
            nm, {24'd0, gnt_s[0], gnt_s[1], done_s[0], done_s[1], err_s[0], err_s[1], mem_write, mem_read}, 32'd0);
        chk(mem_addr == 0 && mem_wdata == 0, {nm, "_addr_data"}, mem_addr | mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        n_chk = 0;
        n_pass = 0;
        mw_cnt = 0;
        cyc = 0;
        for (int p = 0; p < 2; p++) begin
            req_s[p] = 0; we_s[p] = 0; addr_s[p] = 0; wdata_s[p] = 0; last_rd[p] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        mem_init = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk(!gnt_s[0] && !gnt_s[1], "idle_no_gnt", {30'd0, gnt_s[0], gnt_s[1]}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Write then read back through port 0.
        issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
        issue(0, 1'b0, 32'd5, 32'd0, 0);
        idle(3);
        chk(last_rd[0] == 32'hDEAD_BEEF, "rd_back_5", last_rd[0], 32'hDEAD_BEEF);

        // Out-of-range write from port 1 must not reach memory.
        snap = mw_cnt;
        issue(1, 1'b1, 32'd64, 32'hBAD0_BAD0, 0);
        issue(1, 1'b0, 32'd0, 32'd0, 0);
        idle(3);
        chk(mw_cnt == snap, "oor_no_write", 32'(mw_cnt), 32'(snap));
        chk(last_rd[1] == 32'hA5A5_0000, "addr0_intact", last_rd[1], 32'hA5A5_0000);

        // Both ports reading every cycle: strict alternation, each port every 4 cycles.
        gseq.delete();
        gcyc[0].delete();
        gcyc[1].delete();
        fork
            for (int i = 0; i < 6; i++) issue(0, 1'b0, 32'($urandom_range(0, 63)), 32'd0, 0);
            for (int i = 0; i < 6; i++) issue(1, 1'b0, 32'($urandom_range(0, 63)), 32'd0, 0);
        join
        idle(3);
        for (int i = 0; i < gseq.size(); i++)
            chk(gseq[i] == (i % 2), "rr_order", 32'(gseq[i]), 32'(i % 2));
        for (int p = 0; p < 2; p++)
            for (int i = 1; i < gcyc[p].size(); i++)
                chk(gcyc[p][i] - gcyc[p][i-1] == 4, "rr_period", 32'(gcyc[p][i] - gcyc[p][i-1]), 32'd4);

        // Port 1 alone streaming reads: a grant every 2 cycles.
        gcyc[1].delete();
        for (int i = 0; i < 6; i++) issue(1, 1'b0, 32'($urandom_range(0, 63)), 32'd0, 0);
        idle(3);
        chk(gcyc[1].size() == 6, "solo_count", 32'(gcyc[1].size()), 32'd6);
        for (int i = 1; i < gcyc[1].size(); i++)
            chk(gcyc[1][i] - gcyc[1][i-1] == 2, "solo_period", 32'(gcyc[1][i] - gcyc[1][i-1]), 32'd2);

        // Reset during the ACCESS cycle of a write aborts it.
        issue(0, 1'b1, 32'd7, 32'h5555_7777, 0);
        req_s[0] = 1'b1;
        we_s[0] = 1'b1;
        addr_s[0] = 32'd7;
        wdata_s[0] = 32'h0000_1234;
        @(posedge clk);
        #1;
        chk(mem_write && gnt_s[0], "t5_access", {30'd0, mem_write, gnt_s[0]}, 32'd3);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        req_s[0] = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk(!done_s[0] && !gnt_s[0], "no_done_after_rst", {30'd0, done_s[0], gnt_s[0]}, 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'd7, 32'd0, 0);
        idle(3);
        chk(last_rd[0] == 32'h5555_7777, "addr7_prior", last_rd[0], 32'h5555_7777);

        // Random mixed traffic, including out-of-range addresses and idle gaps.
        fork
            for (int i = 0; i < 40; i++)
                issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 67)), $urandom, $urandom_range(0, 2));
            for (int i = 0; i < 40; i++)
                issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 67)), $urandom, $urandom_range(0, 2));
        join
        idle(5);
        for (int p = 0; p < 2; p++) begin
            chk(exp_q[p].size() == 0, "exp_drained", 32'(exp_q[p].size()), 32'd0);
            chk(pend[p].size() == 0, "pend_drained", 32'(pend[p].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
